// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write port bundle for the decode-stage register file
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hold;
  logic [AW-1:0]   wd_reg;
  logic [XLEN-1:0] rdv;
  logic            wren;
  logic [XLEN-1:0] rs1v;
  logic [XLEN-1:0] rs2v;
  logic            ready;

  modport master (
    output rs1, rs2, hold, wd_reg, rdv, wren,
    input  rs1v, rs2v, ready
  );

  modport slave (
    input  rs1, rs2, hold, wd_reg, rdv, wren,
    output rs1v, rs2v, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2R1W register file with sequential clear, read hold, zero entry 0
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN (default read-first).
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREGS];
  logic            clr_last;
  logic            rs1_ok, rs2_ok, wd_ok;
  logic            wr_ok;
  logic [XLEN-1:0] rd1, rd2;

  // A power-of-two file has no unused addresses, so the range check folds away.
  generate
    if (NREGS == (1 << AW)) begin : g_full
      assign rs1_ok = 1'b1;
      assign rs2_ok = 1'b1;
      assign wd_ok  = 1'b1;
    end else begin : g_partial
      assign rs1_ok = (bus.rs1    < AW'(NREGS));
      assign rs2_ok = (bus.rs2    < AW'(NREGS));
      assign wd_ok  = (bus.wd_reg < AW'(NREGS));
    end
  endgenerate

  assign clr_last = (clr_idx == AW'(NREGS - 1));
  assign wr_ok    = !rst && (state_q == RUN) && bus.wren && (bus.wd_reg != '0) && wd_ok;

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_last)
      state_d = RUN;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1_ok && bus.rs1 != '0)
      rd1 = mem[bus.rs1];
    if (rs2_ok && bus.rs2 != '0)
      rd2 = mem[bus.rs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && bus.rs1 == bus.wd_reg)
      rd1 = bus.rdv;
    if (wr_ok && bus.rs2 == bus.wd_reg)
      rd2 = bus.rdv;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx   <= '0;
      bus.ready <= 1'b0;
      bus.rs1v  <= '0;
      bus.rs2v  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_idx  <= clr_idx + 1'b1;
        bus.rs1v <= '0;
        bus.rs2v <= '0;
        if (clr_last)
          bus.ready <= 1'b1;
      end else if (!bus.hold) begin
        bus.rs1v <= rd1;
        bus.rs2v <= rd2;
      end
    end
  end

  // Storage has no reset of its own; the CLEAR walk zeroes it after every rst.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_idx] <= '0;
    else if (wr_ok)
      mem[bus.wd_reg] <= bus.rdv;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the integer register file. Provides two read ports and one write port, with registered reads and a hardwired-zero entry 0. Adds three things the current file lacks: a reset-driven sequential clear of all entries, a read-hold (stall) input for the pipeline, and optional write-to-read forwarding. Sits in the decode stage, between instruction decode and the ALU operand latches.

Parameters:
XLEN, 32, data width of each entry in bits
NREGS, 32, number of entries; must be at least 2
AW, $clog2(NREGS), address width; derived, do not override

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
rs1  in  AW  read address, port 1
rs2  in  AW  read address, port 2
hold  in  1  read stall; 1 = rs1v/rs2v keep their current value
wd_reg  in  AW  write address
rdv  in  XLEN  write data
wren  in  1  write enable
rs1v  out  XLEN  registered read data, port 1
rs2v  out  XLEN  registered read data, port 2
ready  out  1  1 = clear sequence done, file usable

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high (rst).
- FSM has two states, CLEAR and RUN.
- While rst=1:
  - state <= CLEAR, clr_idx <= 0, ready <= 0, rs1v <= 0, rs2v <= 0.
  - rst asserted mid-clear restarts the clear at index 0.
- CLEAR state:
  - Each cycle: entry[clr_idx] <= 0, then clr_idx <= clr_idx + 1.
  - When clr_idx == NREGS-1: that entry is written, state <= RUN, ready <= 1.
  - ready therefore rises exactly NREGS cycles after the first cycle with rst=0.
  - wren is ignored; no user write lands.
  - rs1v/rs2v are held at 0 regardless of hold.
- RUN state, write:
  - Entry is updated on the edge when wren=1, wd_reg != 0 and wd_reg < NREGS.
  - Writes to entry 0 or to an out-of-range address are dropped silently.
- RUN state, read:
  - Latency is 1 cycle: the address presented at edge N gives data on rs1v/rs2v after edge N.
  - If hold=1, rs1v/rs2v keep their value and the addresses are ignored.
  - Address 0 or an address >= NREGS reads as 0.
  - Both ports are independent; rs1 == rs2 is legal and both ports return the same value.
- Same-cycle write and read to the same nonzero address:
  - Result depends on the optional feature below.
  - A write to address 0 is never forwarded.
- hold does not block writes.
- ready stays at 1 until the next rst.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-first. If wren=1, wd_reg != 0, wd_reg < NREGS and rsX == wd_reg, then rsX value = rdv, in the same 1-cycle latency. Forwarding applies per port; if hold=1, hold wins.
- Undefined: read-first. rsX value = the stored value before the write. The new value is visible from the following read.

Test Plan:
- Clear: write 0xDEADBEEF to entry 5, assert rst for 3 cycles, release.
  -> ready=0 for exactly NREGS=32 cycles, then 1; read of entry 5 = 0x00000000.
- Write during clear: wren=1, wd_reg=7, rdv=0x1234 while ready=0.
  -> after ready, entry 7 reads 0.
- Zero register: write wd_reg=0, rdv=0xFFFFFFFF; read rs1=0, rs2=0.
  -> rs1v=rs2v=0.
- Basic read: write entry 3 = 0xA5A5A5A5 and entry 9 = 0x5A5A5A5A; next cycle set rs1=3, rs2=9.
  -> one cycle later rs1v=0xA5A5A5A5, rs2v=0x5A5A5A5A.
- Hold: hold=1 with rs1v=0xA5A5A5A5, change rs1 to 9 for 4 cycles.
  -> rs1v stays 0xA5A5A5A5. Drop hold -> rs1v=0x5A5A5A5A next cycle.
- Collision: entry 4 holds 0x11; same cycle wren=1, wd_reg=4, rdv=0x22, rs1=4.
  -> rs1v=0x22 with REGFILE_BYPASS_EN, 0x11 without; the next read returns 0x22 in both builds.
